lf_read_ser: RTL and testbench
==============================

# lf_read_ser

Parametrised low-frequency reader front end, successor to the fixed 8-bit LF read path. It generates the LF carrier and ADC clock from `pck0`, samples the ADC once per carrier period, and serialises each sample (or an averaged group of samples) MSB-first onto the ARM SSP. It sits between the LF antenna driver/ADC pins and the SSP, in the slot used by the LF read mode in the FPGA mode mux. It adds ADC-width, divisor-width and sample-phase parameters, a glitch-free divisor change, a snoop mode and a divisor-error flag.

## Interface
- `ADC_W`, 8: ADC sample width and serial frame length in bits.
- `DIV_W`, 8: width of `divisor` and of the internal divider counter.
- `SAMPLE_AT`, 7: divider count at which the sample is captured during the low carrier phase.
- `pck0`  in  1  24 MHz system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `divisor`  in  DIV_W  half-period length minus 1, in `pck0` cycles.
- `snoop`  in  1  1 = do not drive carrier (`pwr_lo` held 0); ADC clocking and sampling continue.
- `avg_log2`  in  2  averaging group size = 2^avg_log2 samples (used only with `LF_READ_AVG_EN`).
- `adc_d`  in  ADC_W  ADC output data.
- `adc_clk`  out  1  ADC clock = ~ant_lo.
- `pwr_lo`  out  1  antenna driver = ant_lo & ~snoop.
- `pwr_hi`, `pwr_oe1`..`pwr_oe4`  out  1 each  constant 0.
- `ssp_clk`  out  1  = `pck0`.
- `ssp_frame`  out  1  high while serial bits are valid.
- `ssp_din`  out  1  serial data, MSB first.
- `div_err`  out  1  sticky: a sample was skipped because the divisor was too small.
- `dbg`  out  1  = `adc_clk`.

## Operation
- Divider: counter `cnt` (DIV_W) and latched divisor `div_q`. When `cnt == div_q`: `cnt` <= 0, ant_lo toggles, `div_q` <= `divisor`. Otherwise `cnt` increments.
- `divisor` changes therefore take effect only at a half-period boundary, so there are no runt pulses.
- Carrier period = 2·(div_q+1) `pck0` cycles.
- Capture: on the edge where `cnt == SAMPLE_AT`, ant_lo == 0 and `div_q >= SAMPLE_AT + ADC_W`, `adc_d` is captured.
- If that condition holds except for the divisor check, no capture happens and `div_err` sets. `div_err` clears only on `reset`.
- Serialiser: `shreg` (ADC_W) and `bitcnt`.
  - A frame start loads `shreg` and `bitcnt = ADC_W`.
  - Each later edge shifts `shreg` left with 0 fill and decrements `bitcnt`.
  - `ssp_frame` is registered and equals (`bitcnt != 0`).
  - `ssp_din` = `shreg[ADC_W-1]` & `ssp_frame`, so it is 0 outside frames.
- Without averaging, every capture starts a frame with the raw sample.
- Frames never overlap: the divisor check guarantees a frame completes before ant_lo rises.
- `snoop` affects only `pwr_lo`. It may change at any time and is applied combinationally.
- Reset values: `cnt`=0, ant_lo=0 (so `adc_clk`=1, `pwr_lo`=0), `div_q`=0, `shreg`=0, `bitcnt`=0, `ssp_frame`=0, `ssp_din`=0, `div_err`=0, accumulator and group count 0.
- After reset, `div_q`=0 gives a first half-period of 1 cycle, after which `div_q` = `divisor`.
- Reset asserted mid-frame drops `ssp_frame` and `ssp_din` immediately (asynchronous). No partial frame resumes.

## Timing
- Capture at edge E. `ssp_frame` is high from after E until after E+ADC_W, i.e. exactly ADC_W cycles.
- Bit k (MSB = k 0) is valid on `ssp_din` between edges E+k and E+k+1. The ARM samples on the falling `ssp_clk` edge.
- Latency from the `adc_d` capture edge to the MSB on `ssp_din`: 1 `pck0` cycle.
- The `cnt` values during the frame are SAMPLE_AT+1 .. SAMPLE_AT+ADC_W, all in the low phase.

## Configuration
- `LF_READ_AVG_EN` defined:
  - An accumulator of ADC_W+3 bits sums 2^g captured samples, where g is `avg_log2` latched at the first sample of each group.
  - Only the last capture of a group starts a frame, carrying (acc + sample) >> g truncated to ADC_W bits.
  - The accumulator then clears.
  - g = 0 behaves identically to the non-averaging build.
  - Skipped captures (`div_err` case) do not count toward the group.
- `LF_READ_AVG_EN` undefined: no accumulator, `avg_log2` is ignored, and every capture is framed.

## Test plan
- Reset release, divisor=95, `adc_d`=8'hA5:
  - carrier period is 192 cycles (125 kHz);
  - `ssp_frame` is high for 8 cycles starting 1 cycle after `cnt`=7 in the low phase;
  - `ssp_din` serialises 1,0,1,0,0,1,0,1, then 0.
- Change divisor 95→47 mid half-period: the current half-period completes at 96 cycles and the next is 48 cycles, with no shorter pulse on `pwr_lo`.
- divisor=10, SAMPLE_AT=7, ADC_W=8: no frames are produced and `div_err` rises at the first low-phase `cnt`=7 and stays high. Setting divisor=15 resumes frames.
- `snoop`=1, divisor=95: `pwr_lo` stays 0, `adc_clk` still toggles every 96 cycles, and frames continue.
- `LF_READ_AVG_EN`, avg_log2=2, samples 10, 20, 30, 41: one frame carrying 8'd25 after the 4th capture, and no frames for the first three.
- Assert `reset` during bit 3 of a frame: `ssp_frame` and `ssp_din` go 0 without waiting for a clock, and after release the first frame is a complete fresh sample.

Source files
------------

// File: rtl/lf_read_ser.sv
// LF reader front end: carrier/ADC clock divider, one ADC capture per carrier period, MSB-first SSP serialiser (sample averaging with LF_READ_AVG_EN).
// Latency: 1 pck0 cycle from the capture edge to the MSB on ssp_din; each frame lasts ADC_W cycles.
// Backpressure: none; the ARM must take every frame, and the divisor check keeps frames from overlapping.
module lf_read_ser #(
  parameter int ADC_W     = 8,
  parameter int DIV_W     = 8,
  parameter int SAMPLE_AT = 7
) (
  input  logic             pck0,
  input  logic             reset,
  input  logic [DIV_W-1:0] divisor,
  input  logic             snoop,
  input  logic [1:0]       avg_log2,
  input  logic [ADC_W-1:0] adc_d,
  output logic             adc_clk,
  output logic             pwr_lo,
  output logic             pwr_hi,
  output logic             pwr_oe1,
  output logic             pwr_oe2,
  output logic             pwr_oe3,
  output logic             pwr_oe4,
  output logic             ssp_clk,
  output logic             ssp_frame,
  output logic             ssp_din,
  output logic             div_err,
  output logic             dbg
);
  localparam int               BC_W       = $clog2(ADC_W + 1);
  localparam logic [DIV_W:0]   MIN_DIV    = (DIV_W + 1)'(SAMPLE_AT + ADC_W);
  localparam logic [DIV_W-1:0] SAMPLE_CNT = DIV_W'(SAMPLE_AT);
  localparam logic [BC_W-1:0]  BITS       = BC_W'(ADC_W);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic             ant_lo;
  logic [ADC_W-1:0] shreg;
  logic [BC_W-1:0]  bitcnt;
  logic             sample_pt;
  logic             div_ok;
  logic             capture;
  logic             frame_start;
  logic [ADC_W-1:0] frame_dat;

  // A sample is only taken when the whole frame fits inside the low phase.
  assign sample_pt = (cnt == SAMPLE_CNT) && !ant_lo;
  assign div_ok    = {1'b0, div_q} >= MIN_DIV;
  assign capture   = sample_pt && div_ok;

  // Divisor is latched only at half-period boundaries, so a change never produces a runt pulse.
  always_ff @(posedge pck0 or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      div_q  <= '0;
      ant_lo <= 1'b0;
    end else if (cnt == div_q) begin
      cnt    <= '0;
      div_q  <= divisor;
      ant_lo <= ~ant_lo;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge pck0 or posedge reset) begin
    if (reset) begin
      div_err <= 1'b0;
    end else if (sample_pt && !div_ok) begin
      div_err <= 1'b1;
    end
  end

`ifdef LF_READ_AVG_EN
  localparam int ACC_W = ADC_W + 3;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] avg_full;
  logic [2:0]       grp_cnt;
  logic [2:0]       grp_last;
  logic [1:0]       g_q;
  logic [1:0]       g_cur;
  logic             last_cap;

  // Group size is fixed by avg_log2 as seen at the first capture of each group.
  always_comb begin
    g_cur    = (grp_cnt == 3'd0) ? avg_log2 : g_q;
    grp_last = 3'((4'd1 << g_cur) - 4'd1);
    acc_sum  = acc + ACC_W'(adc_d);
    avg_full = acc_sum >> g_cur;
  end

  assign last_cap    = (grp_cnt == grp_last);
  assign frame_start = capture && last_cap;
  assign frame_dat   = avg_full[ADC_W-1:0];

  always_ff @(posedge pck0 or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      grp_cnt <= '0;
      g_q     <= '0;
    end else if (capture) begin
      g_q <= g_cur;
      if (last_cap) begin
        acc     <= '0;
        grp_cnt <= '0;
      end else begin
        acc     <= acc_sum;
        grp_cnt <= grp_cnt + 3'd1;
      end
    end
  end
`else
  logic unused_avg;

  assign unused_avg  = ^avg_log2;
  assign frame_start = capture;
  assign frame_dat   = adc_d;
`endif

  always_ff @(posedge pck0 or posedge reset) begin
    if (reset) begin
      shreg     <= '0;
      bitcnt    <= '0;
      ssp_frame <= 1'b0;
    end else if (frame_start) begin
      shreg     <= frame_dat;
      bitcnt    <= BITS;
      ssp_frame <= 1'b1;
    end else if (bitcnt != '0) begin
      shreg     <= {shreg[ADC_W-2:0], 1'b0};
      bitcnt    <= bitcnt - BC_W'(1);
      ssp_frame <= (bitcnt != BC_W'(1));
    end
  end

  assign ssp_din = shreg[ADC_W-1] & ssp_frame;
  assign ssp_clk = pck0;
  assign adc_clk = ~ant_lo;
  assign dbg     = ~ant_lo;
  assign pwr_lo  = ant_lo & ~snoop;
  assign pwr_hi  = 1'b0;
  assign pwr_oe1 = 1'b0;
  assign pwr_oe2 = 1'b0;
  assign pwr_oe3 = 1'b0;
  assign pwr_oe4 = 1'b0;
endmodule

// File: tb/tb_lf_read_ser.sv
// Directed bench for lf_read_ser: expected frames queued with the stimulus, checked as the SSP frames arrive.
module tb_lf_read_ser;
  localparam int ADC_W = 8;
  localparam int DIV_W = 8;

  logic             pck0 = 1'b0;
  logic             reset;
  logic [DIV_W-1:0] divisor;
  logic             snoop;
  logic [1:0]       avg_log2;
  logic [ADC_W-1:0] adc_d;
  logic adc_clk, pwr_lo, pwr_hi, pwr_oe1, pwr_oe2, pwr_oe3, pwr_oe4;
  logic ssp_clk, ssp_frame, ssp_din, div_err, dbg;

  int               tests = 0;
  int               fails = 0;
  int               frames_done = 0;
  int               bits_seen = 0;
  logic [ADC_W-1:0] rx = '0;
  logic [ADC_W-1:0] exp_q[$];

  always #5 pck0 = ~pck0;

  lf_read_ser #(.ADC_W(ADC_W), .DIV_W(DIV_W), .SAMPLE_AT(7)) dut (
    .pck0(pck0), .reset(reset), .divisor(divisor), .snoop(snoop), .avg_log2(avg_log2),
    .adc_d(adc_d), .adc_clk(adc_clk), .pwr_lo(pwr_lo), .pwr_hi(pwr_hi),
    .pwr_oe1(pwr_oe1), .pwr_oe2(pwr_oe2), .pwr_oe3(pwr_oe3), .pwr_oe4(pwr_oe4),
    .ssp_clk(ssp_clk), .ssp_frame(ssp_frame), .ssp_din(ssp_din), .div_err(div_err), .dbg(dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [ADC_W-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic skip(input int n);
    repeat (n) @(negedge pck0);
  endtask

  task automatic wait_adc(input logic lvl, output int n);
    n = 0;
    do begin
      @(negedge pck0);
      n++;
    end while (adc_clk !== lvl && n < 1000);
    if (adc_clk !== lvl) check("timeout_adc_clk", adc_clk, lvl);
  endtask

  task automatic wait_frame(output int n);
    n = 0;
    do begin
      @(negedge pck0);
      n++;
    end while (ssp_frame !== 1'b1 && n < 1000);
    if (ssp_frame !== 1'b1) check("timeout_frame", ssp_frame, 1);
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (frames_done < target && n < 600) begin
      @(negedge pck0);
      n++;
    end
    check("frames_done", frames_done, target);
  endtask

  // Frame collector: shifts in ssp_din while ssp_frame is high and scores each full frame.
  always @(negedge pck0) begin
    if (reset) begin
      bits_seen = 0;
    end else if (ssp_frame) begin
      rx = {rx[ADC_W-2:0], ssp_din};
      bits_seen++;
      if (bits_seen == ADC_W) begin
        check("frame_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("frame_data", rx, exp_q.pop_front());
        frames_done++;
      end else if (bits_seen == ADC_W + 1) begin
        check("frame_len_long", bits_seen, ADC_W);
      end
    end else begin
      check("din_idle", ssp_din, 0);
      if (bits_seen != 0 && bits_seen != ADC_W) check("frame_len_short", bits_seen, ADC_W);
      bits_seen = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c1, c2, nf;
    reset = 1'b1; divisor = 8'd95; snoop = 1'b0; avg_log2 = 2'd0; adc_d = 8'hA5;
    #12;
    check("rst_adc_clk", adc_clk, 1);
    check("rst_dbg", dbg, 1);
    check("rst_pwr_lo", pwr_lo, 0);
    check("rst_frame", ssp_frame, 0);
    check("rst_din", ssp_din, 0);
    check("rst_div_err", div_err, 0);
    check("rst_const", {pwr_hi, pwr_oe1, pwr_oe2, pwr_oe3, pwr_oe4}, 0);
    check("ssp_clk", ssp_clk, pck0);
    @(negedge pck0);
    reset = 1'b0;

    // divisor 95, sample A5
    push(8'hA5);
    wait_adc(1'b0, c); check("first_half", c, 1);
    wait_adc(1'b1, c); check("high_half", c, 96);
    wait_frame(c);     check("frame_delay", c, 8);
    wait_done(1);
    push(8'hA5);
    wait_adc(1'b0, c);
    wait_adc(1'b1, c1); check("high_half2", c1, 96);
    check("pwr_lo_low", pwr_lo, 0);
    wait_adc(1'b0, c2); check("carrier_period", c1 + c2, 192);
    check("pwr_lo_high", pwr_lo, 1);
    check("dbg_high_phase", dbg, 0);
    wait_done(2);

    // divisor 95 -> 47 mid half-period
    adc_d = 8'h5A; push(8'h5A); push(8'h5A);
    skip(40);
    divisor = 8'd47;
    wait_adc(1'b1, c); check("div_chg_cur_half", c, 56);
    wait_adc(1'b0, c); check("div_chg_next_half", c, 48);
    check("pwr_lo_after_chg", pwr_lo, 1);
    wait_adc(1'b1, c); check("pwr_lo_pulse_len", c, 48);
    wait_done(4);

    // divisor too small: no frames, sticky div_err
    divisor = 8'd10;
    wait_adc(1'b0, c);
    wait_adc(1'b1, c); check("short_half", c, 11);
    skip(7); check("div_err_before", div_err, 0);
    skip(1); check("div_err_set", div_err, 1);
    skip(100);
    check("div_err_sticky", div_err, 1);
    check("no_frames_small_div", frames_done, 4);

    divisor = 8'd15; adc_d = 8'h3C; push(8'h3C);
    wait_adc(1'b0, c);
    wait_adc(1'b1, c);
    wait_done(5);
    check("div_err_hold", div_err, 1);

    // snoop: carrier off, ADC clocking and frames continue
    divisor = 8'd95; snoop = 1'b1; adc_d = 8'hC3; push(8'hC3); push(8'hC3);
    wait_adc(1'b0, c);
    wait_adc(1'b1, c);
    check("snoop_pwr_lo_l", pwr_lo, 0);
    wait_adc(1'b0, c); check("snoop_low_half", c, 96);
    check("snoop_pwr_lo_h", pwr_lo, 0);
    wait_adc(1'b1, c); check("snoop_high_half", c, 96);
    wait_done(7);
    snoop = 1'b0;
    nf = 7;

`ifdef LF_READ_AVG_EN
    avg_log2 = 2'd2;
    wait_adc(1'b0, c); adc_d = 8'd10; wait_adc(1'b1, c); skip(20);
    wait_adc(1'b0, c); adc_d = 8'd20; wait_adc(1'b1, c); skip(20);
    wait_adc(1'b0, c); adc_d = 8'd30; avg_log2 = 2'd0; wait_adc(1'b1, c); skip(20);
    check("avg_no_early_frames", frames_done, nf);
    push(8'd25);
    wait_adc(1'b0, c); adc_d = 8'd41; wait_adc(1'b1, c);
    nf = nf + 1;
    wait_done(nf);
`endif

    // reset in the middle of a frame
    adc_d = 8'hFF; push(8'hFF);
    wait_adc(1'b0, c);
    wait_adc(1'b1, c);
    wait_frame(c);
    skip(3);
    check("din_bit3_before_rst", ssp_din, 1);
    reset = 1'b1;
    #1;
    check("rst_frame_async", ssp_frame, 0);
    check("rst_din_async", ssp_din, 0);
    check("rst_div_err_clr", div_err, 0);
    exp_q.delete();
    @(negedge pck0);
    reset = 1'b0; adc_d = 8'h69; push(8'h69);
    wait_adc(1'b0, c); check("rst2_first_half", c, 1);
    wait_adc(1'b1, c); check("rst2_high_half", c, 96);
    wait_done(nf + 1);
    skip(20);
    check("queue_empty", exp_q.size(), 0);
    check("frames_total", frames_done, nf + 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
